// File: rtl/pool_kxk_stream_pkg.sv
// Shared encodings and sizing helpers for the KxK pooling stage.
// With POOL_AVG_EN defined the accumulators widen to hold a full window sum.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;
  localparam int DEF_K     = 2;
  localparam int DEF_OW    = DEF_IMG_W / DEF_K;
  localparam int DEF_OH    = DEF_IMG_H / DEF_K;
  localparam int DEF_N     = DEF_OW * DEF_OH;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int dw, input int k);
`ifdef POOL_AVG_EN
    return dw + 2 * $clog2(k);
`else
    return dw + 0 * k;
`endif
  endfunction

  function automatic int acc_shift(input int k);
    return 2 * $clog2(k);
  endfunction

  localparam int DEF_AW = acc_width(DEF_DW, DEF_K);
  localparam int DEF_SH = acc_shift(DEF_K);

endpackage

// File: rtl/pool_kxk_stream_if.sv
// Sample stream into the pooling stage and pooled-pixel stream out of it.
interface pool_kxk_stream_if #(
  parameter int DW    = 8,
  parameter int IDX_W = 2
);
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [IDX_W-1:0]     out_idx;

  modport master (output in_valid, in_data, input out_valid, out_data, out_idx);
  modport slave  (input in_valid, in_data, output out_valid, out_data, out_idx);
endinterface

// File: rtl/pool_kxk_stream_acc_op.sv
// Combinational update of one pooling accumulator (max, or sum under POOL_AVG_EN).
module pool_acc_op
  import pool_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int SH = 2
) (
  input  logic                 first,
`ifdef POOL_AVG_EN
  input  logic                 mode,
`endif
  input  logic signed [AW-1:0] acc,
  input  logic signed [DW-1:0] in,
  output logic signed [AW-1:0] next_acc,
  output logic signed [DW-1:0] result
);
  logic signed [AW-1:0] in_ext;

  assign in_ext = AW'(in);

  always_comb begin
    // The first sample of a window loads directly so stale band data never wins.
    if (first) begin
      next_acc = in_ext;
    end
`ifdef POOL_AVG_EN
    else if (mode == POOL_AVG) begin
      next_acc = acc + in_ext;
    end
`endif
    else if (in_ext > acc) begin
      next_acc = in_ext;
    end else begin
      next_acc = acc;
    end
    result = next_acc[DW-1:0];
`ifdef POOL_AVG_EN
    if (mode == POOL_AVG) begin
      result = DW'(next_acc >>> SH);
    end
`endif
  end
endmodule

// File: rtl/pool_kxk_stream.sv
// Streaming KxK pooling after the conv engine; pooled map kept in pool_lin_reg.
// Build option POOL_AVG_EN adds the mode port and the floor-average datapath.
module pool_kxk_stream
  import pool_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K     = DEF_K
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
`ifdef POOL_AVG_EN
  input  logic                          mode,
`endif
  pool_kxk_stream_if.slave              stream,
  output logic                          busy,
  output logic                          frame_done,
  output logic [(IMG_W/K)*(IMG_H/K)*DW-1:0] pool_lin_reg
);
  localparam int OW    = IMG_W / K;
  localparam int OH    = IMG_H / K;
  localparam int N     = OW * OH;
  localparam int IDX_W = idx_width(N);
  localparam int AW    = acc_width(DW, K);
  localparam int SH    = acc_shift(K);
  localparam int LK    = $clog2(K);
  localparam int CW    = idx_width(IMG_W);
  localparam int RW    = idx_width(IMG_H);
  localparam int OCW   = idx_width(OW);

  pool_state_e          state_reg;
  logic [CW-1:0]        col_reg;
  logic [RW-1:0]        row_reg;
  logic                 busy_reg;
  logic                 frame_done_reg;
  logic                 out_valid_reg;
  logic signed [DW-1:0] out_data_reg;
  logic [IDX_W-1:0]     out_idx_reg;
`ifdef POOL_AVG_EN
  logic                 mode_reg;
`endif

  logic signed [AW-1:0] acc_flat [OW];
  logic signed [AW-1:0] acc_sel;
  logic signed [AW-1:0] next_acc;
  logic signed [DW-1:0] result;
  logic [OCW-1:0]       oc;
  logic [IDX_W-1:0]     out_idx_next;
  logic                 in_win;
  logic                 win_first;
  logic                 win_last;
  logic                 last_sample;
  logic                 accept;
  logic                 acc_we;
  logic                 out_we;

  assign oc           = OCW'(col_reg >> LK);
  assign win_first    = (col_reg[LK-1:0] == '0) && (row_reg[LK-1:0] == '0);
  assign win_last     = (&col_reg[LK-1:0]) && (&row_reg[LK-1:0]);
  // Trailing columns/rows that do not fill a whole window are only counted.
  assign in_win       = (int'(col_reg) < OW * K) && (int'(row_reg) < OH * K);
  assign last_sample  = (int'(col_reg) == IMG_W - 1) && (int'(row_reg) == IMG_H - 1);
  assign accept       = (state_reg == ST_RUN) && stream.in_valid && !start;
  assign acc_we       = accept && in_win;
  assign out_we       = acc_we && win_last;
  assign acc_sel      = in_win ? acc_flat[oc] : '0;
  assign out_idx_next = IDX_W'(int'(row_reg >> LK) * OW + int'(oc));

  pool_acc_op #(
    .DW (DW),
    .AW (AW),
    .SH (SH)
  ) u_acc_op (
    .first    (win_first),
`ifdef POOL_AVG_EN
    .mode     (mode_reg),
`endif
    .acc      (acc_sel),
    .in       (stream.in_data),
    .next_acc (next_acc),
    .result   (result)
  );

  for (genvar gi = 0; gi < OW; gi++) begin : g_acc
    logic signed [AW-1:0] acc_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg <= '0;
      end else if (start) begin
        acc_reg <= '0;
      end else if (acc_we && (oc == OCW'(gi))) begin
        acc_reg <= next_acc;
      end
    end
    assign acc_flat[gi] = acc_reg;
  end

  // Pooled map survives a restart; each pixel is only replaced when recomputed.
  for (genvar gi = 0; gi < N; gi++) begin : g_lin
    logic [DW-1:0] pix_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pix_reg <= '0;
      end else if (out_we && (out_idx_next == IDX_W'(gi))) begin
        pix_reg <= result;
      end
    end
    assign pool_lin_reg[gi*DW +: DW] = pix_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_idx_reg    <= '0;
`ifdef POOL_AVG_EN
      mode_reg       <= POOL_MAX;
`endif
    end else begin
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      if (start) begin
        state_reg <= ST_RUN;
        busy_reg  <= 1'b1;
        col_reg   <= '0;
        row_reg   <= '0;
`ifdef POOL_AVG_EN
        mode_reg  <= mode;
`endif
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (stream.in_valid) begin
              if (out_we) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= result;
                out_idx_reg   <= out_idx_next;
              end
              if (int'(col_reg) == IMG_W - 1) begin
                col_reg <= '0;
                row_reg <= last_sample ? '0 : row_reg + 1'b1;
              end else begin
                col_reg <= col_reg + 1'b1;
              end
              if (last_sample) begin
                state_reg      <= ST_DONE;
                busy_reg       <= 1'b0;
                frame_done_reg <= 1'b1;
              end
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy             = busy_reg;
  assign frame_done       = frame_done_reg;
  assign stream.out_valid = out_valid_reg;
  assign stream.out_data  = out_data_reg;
  assign stream.out_idx   = out_idx_reg;
endmodule

// File: tb/tb_pool_kxk_stream.sv
// Directed bench: 4x4 and 5x4 instances, K=2, DW=8; average frame only under POOL_AVG_EN.
module tb_pool_kxk_stream;
  localparam int DW    = 8;
  localparam int K     = 2;
  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0;
  logic start5 = 1'b0;
  logic mode = 1'b0;
  logic busy4, busy5, fd4, fd5;
  logic [N*DW-1:0] lin4, lin5;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pool_kxk_stream_if #(.DW(DW), .IDX_W(IDX_W)) s4 ();
  pool_kxk_stream_if #(.DW(DW), .IDX_W(IDX_W)) s5 ();

  pool_kxk_stream #(.DW(DW), .IMG_W(4), .IMG_H(4), .K(K)) u4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start4),
`ifdef POOL_AVG_EN
    .mode         (mode),
`endif
    .stream       (s4),
    .busy         (busy4),
    .frame_done   (fd4),
    .pool_lin_reg (lin4)
  );

  pool_kxk_stream #(.DW(DW), .IMG_W(5), .IMG_H(4), .K(K)) u5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start5),
`ifdef POOL_AVG_EN
    .mode         (mode),
`endif
    .stream       (s5),
    .busy         (busy5),
    .frame_done   (fd5),
    .pool_lin_reg (lin5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s4.in_valid = 1'b0; s4.in_data = '0;
    s5.in_valid = 1'b0; s5.in_data = '0;
    rst_n = 1'b0;
    step(); step();
    compared++;
    if ({busy4, fd4, s4.out_valid, s4.out_data, s4.out_idx} !== '0) begin
      mismatched++;
      $display("FAIL reset_u4_outputs got busy=%0b fd=%0b ov=%0b od=%0d oi=%0d want all 0",
               busy4, fd4, s4.out_valid, s4.out_data, s4.out_idx);
    end
    compared++;
    if ({busy5, fd5, s5.out_valid, s5.out_data, s5.out_idx} !== '0) begin
      mismatched++;
      $display("FAIL reset_u5_outputs got busy=%0b fd=%0b ov=%0b want all 0", busy5, fd5, s5.out_valid);
    end
    compared++;
    if (lin4 !== '0 || lin5 !== '0) begin
      mismatched++;
      $display("FAIL reset_lin got %h/%h want 0", lin4, lin5);
    end
    rst_n = 1'b1;
    step();
    $display("reset: checked");
  endtask

  task automatic test_ramp();
    logic signed [7:0] ev [4];
    int pulses;
    int k;
    ev = '{8'sd5, 8'sd7, 8'sd13, 8'sd15};
    pulses = 0;
    start4 = 1'b1; step(); start4 = 1'b0;
    compared++;
    if (busy4 !== 1'b1) begin mismatched++; $display("FAIL ramp_busy got %0b want 1", busy4); end
    for (int i = 0; i < 16; i++) begin
      s4.in_valid = 1'b1; s4.in_data = 8'(i);
      step();
      k = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1;
      compared++;
      if (s4.out_valid !== (k >= 0)) begin
        mismatched++;
        $display("FAIL ramp_out_valid sample %0d got %0b want %0b", i, s4.out_valid, k >= 0);
      end
      if (k >= 0) begin
        pulses++;
        compared++;
        if (s4.out_data !== ev[k] || s4.out_idx !== 2'(k)) begin
          mismatched++;
          $display("FAIL ramp_pixel sample %0d got %0d@%0d want %0d@%0d",
                   i, $signed(s4.out_data), s4.out_idx, ev[k], k);
        end
      end
      compared++;
      if (fd4 !== (i == 15)) begin
        mismatched++;
        $display("FAIL ramp_frame_done sample %0d got %0b want %0b", i, fd4, i == 15);
      end
    end
    s4.in_valid = 1'b0;
    compared++;
    if (busy4 !== 1'b0) begin mismatched++; $display("FAIL ramp_busy_done got %0b want 0", busy4); end
    compared++;
    if (lin4 !== 32'h0F0D0705) begin mismatched++; $display("FAIL ramp_lin got %h want 0f0d0705", lin4); end
    step();
    compared++;
    if (fd4 !== 1'b0 || s4.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ramp_pulse_width got fd=%0b ov=%0b want 0/0", fd4, s4.out_valid);
    end
    $display("ramp: %0d pulses", pulses);
  endtask

  task automatic test_negative();
    logic signed [7:0] d [16];
    logic signed [7:0] ev [4];
    int k;
    d  = '{-8'sd128, -8'sd5, 8'sd10, 8'sd20, -8'sd7, -8'sd100, 8'sd30, -8'sd40,
           -8'sd1, -8'sd2, -8'sd3, -8'sd4, -8'sd50, -8'sd60, -8'sd70, -8'sd80};
    ev = '{-8'sd5, 8'sd30, -8'sd1, -8'sd3};
    start4 = 1'b1; step(); start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s4.in_valid = 1'b1; s4.in_data = d[i];
      step();
      k = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1;
      if (k >= 0) begin
        compared++;
        if (s4.out_valid !== 1'b1 || s4.out_data !== ev[k] || s4.out_idx !== 2'(k)) begin
          mismatched++;
          $display("FAIL negative_pixel sample %0d got v=%0b %0d@%0d want %0d@%0d",
                   i, s4.out_valid, $signed(s4.out_data), s4.out_idx, ev[k], k);
        end
      end
    end
    s4.in_valid = 1'b0;
    compared++;
    if (lin4 !== 32'hFDFF1EFB) begin mismatched++; $display("FAIL negative_lin got %h want fdff1efb", lin4); end
    step();
    $display("negative: checked");
  endtask

  task automatic test_gaps();
    int gap [16];
    int pulses;
    gap = '{0, 2, 1, 0, 3, 0, 1, 1, 0, 0, 2, 0, 1, 0, 0, 3};
    pulses = 0;
    start4 = 1'b1; step(); start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        s4.in_valid = 1'b0; s4.in_data = 8'h55;
        step();
        compared++;
        if (s4.out_valid !== 1'b0 || fd4 !== 1'b0) begin
          mismatched++;
          $display("FAIL gaps_idle before sample %0d got ov=%0b fd=%0b want 0/0", i, s4.out_valid, fd4);
        end
      end
      s4.in_valid = 1'b1; s4.in_data = 8'(i);
      step();
      if (s4.out_valid === 1'b1) pulses++;
    end
    s4.in_valid = 1'b0;
    compared++;
    if (pulses !== 4 || fd4 !== 1'b1) begin
      mismatched++;
      $display("FAIL gaps_pulses got %0d fd=%0b want 4 fd=1", pulses, fd4);
    end
    compared++;
    if (lin4 !== 32'h0F0D0705) begin mismatched++; $display("FAIL gaps_lin got %h want 0f0d0705", lin4); end
    step();
    $display("gaps: %0d pulses", pulses);
  endtask

  task automatic test_trailing();
    logic signed [7:0] ev [4];
    int pulses;
    int k;
    ev = '{8'sd6, 8'sd8, 8'sd16, 8'sd18};
    pulses = 0;
    start5 = 1'b1; step(); start5 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s5.in_valid = 1'b1; s5.in_data = 8'(i);
      step();
      k = (i == 6) ? 0 : (i == 8) ? 1 : (i == 16) ? 2 : (i == 18) ? 3 : -1;
      if (s5.out_valid === 1'b1) pulses++;
      if (k >= 0) begin
        compared++;
        if (s5.out_valid !== 1'b1 || s5.out_data !== ev[k] || s5.out_idx !== 2'(k)) begin
          mismatched++;
          $display("FAIL trailing_pixel sample %0d got v=%0b %0d@%0d want %0d@%0d",
                   i, s5.out_valid, $signed(s5.out_data), s5.out_idx, ev[k], k);
        end
      end
      compared++;
      if (fd5 !== (i == 19)) begin
        mismatched++;
        $display("FAIL trailing_frame_done sample %0d got %0b want %0b", i, fd5, i == 19);
      end
    end
    s5.in_valid = 1'b0;
    compared++;
    if (pulses !== 4) begin mismatched++; $display("FAIL trailing_pulses got %0d want 4", pulses); end
    compared++;
    if (lin5 !== 32'h12100806) begin mismatched++; $display("FAIL trailing_lin got %h want 12100806", lin5); end
    step();
    $display("trailing: %0d pulses", pulses);
  endtask

  task automatic test_abort();
    logic signed [7:0] ev [4];
    int pulses;
    int k;
    ev = '{8'sd5, 8'sd7, 8'sd13, 8'sd15};
    pulses = 0;
    start4 = 1'b1; step(); start4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s4.in_valid = 1'b1; s4.in_data = 8'sd100;
      step();
    end
    compared++;
    if (s4.out_valid !== 1'b1 || s4.out_data !== 8'sd100) begin
      mismatched++;
      $display("FAIL abort_partial_pixel got v=%0b %0d want 1 100", s4.out_valid, $signed(s4.out_data));
    end
    // Restart with a sample offered in the same cycle; it must be dropped.
    start4 = 1'b1; s4.in_valid = 1'b1; s4.in_data = 8'sd99;
    step();
    start4 = 1'b0;
    compared++;
    if (s4.out_valid !== 1'b0 || busy4 !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_restart got ov=%0b busy=%0b want 0/1", s4.out_valid, busy4);
    end
    for (int i = 0; i < 16; i++) begin
      s4.in_valid = 1'b1; s4.in_data = 8'(i);
      step();
      k = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1;
      if (s4.out_valid === 1'b1) pulses++;
      if (k >= 0) begin
        compared++;
        if (s4.out_valid !== 1'b1 || s4.out_data !== ev[k] || s4.out_idx !== 2'(k)) begin
          mismatched++;
          $display("FAIL abort_pixel sample %0d got v=%0b %0d@%0d want %0d@%0d",
                   i, s4.out_valid, $signed(s4.out_data), s4.out_idx, ev[k], k);
        end
      end
    end
    s4.in_valid = 1'b0;
    compared++;
    if (pulses !== 4 || fd4 !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_pulses got %0d fd=%0b want 4 fd=1", pulses, fd4);
    end
    compared++;
    if (lin4 !== 32'h0F0D0705) begin mismatched++; $display("FAIL abort_lin got %h want 0f0d0705", lin4); end
    step();
    $display("abort: %0d pulses", pulses);
  endtask

`ifdef POOL_AVG_EN
  task automatic test_avg();
    logic signed [7:0] d [16];
    logic signed [7:0] ev [4];
    int k;
    d  = '{-8'sd1, -8'sd2, 8'sd1, 8'sd2, -8'sd3, -8'sd4, 8'sd3, 8'sd5,
           8'sd7, 8'sd7, -8'sd8, -8'sd8, 8'sd7, 8'sd6, -8'sd8, -8'sd8};
    ev = '{-8'sd3, 8'sd2, 8'sd6, -8'sd8};
    mode = 1'b1; start4 = 1'b1; step(); start4 = 1'b0; mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s4.in_valid = 1'b1; s4.in_data = d[i];
      step();
      k = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1;
      if (k >= 0) begin
        compared++;
        if (s4.out_valid !== 1'b1 || s4.out_data !== ev[k] || s4.out_idx !== 2'(k)) begin
          mismatched++;
          $display("FAIL avg_pixel sample %0d got v=%0b %0d@%0d want %0d@%0d",
                   i, s4.out_valid, $signed(s4.out_data), s4.out_idx, ev[k], k);
        end
      end
    end
    s4.in_valid = 1'b0;
    compared++;
    if (lin4 !== 32'hF80602FD) begin mismatched++; $display("FAIL avg_lin got %h want f80602fd", lin4); end
    step();
    $display("avg: checked");
  endtask
`endif

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    start4 = 1'b1; step(); start4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s4.in_valid = 1'b1; s4.in_data = 8'(i);
      step();
    end
    s4.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (busy4 !== 1'b0 || lin4 !== '0) begin
      mismatched++;
      $display("FAIL async_reset got busy=%0b lin=%h want 0/0", busy4, lin4);
    end
    step();
    rst_n = 1'b1;
    // Samples offered while idle must be ignored.
    for (int i = 0; i < 16; i++) begin
      s4.in_valid = 1'b1; s4.in_data = 8'(i);
      step();
      if (s4.out_valid === 1'b1 || fd4 === 1'b1 || busy4 === 1'b1) pulses++;
    end
    s4.in_valid = 1'b0;
    compared++;
    if (pulses !== 0) begin mismatched++; $display("FAIL idle_ignore got %0d active cycles want 0", pulses); end
    $display("async_reset: checked");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_gaps();
    test_trailing();
    test_abort();
`ifdef POOL_AVG_EN
    test_avg();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pool_kxk_stream.md
# pool_kxk_stream

Streaming, parametrised K×K pooling stage that sits directly after the convolution engine. It consumes conv results in raster order under a valid strobe and needs no externally supplied phase counter. It emits each pooled pixel as a one-cycle pulse and keeps the whole pooled map in a flattened register vector for the linear layer. Window size, stride, image size and data width are set by parameters. Average pooling is optional at compile time.

## Interface
- `DW`, 8: signed sample width.
- `IMG_W`, 8: input columns per row.
- `IMG_H`, 8: input rows per frame.
- `K`, 2: window size and stride. Must be a power of two and at least 2.
- Derived: `OW = IMG_W/K`, `OH = IMG_H/K` (floor division); `N = OW*OH`.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a new frame.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_data`, input, DW: signed conv sample.
- `mode`, input, 1: 0 = max, 1 = average. Present only with `POOL_AVG_EN`.
- `busy`, output, 1: frame in progress.
- `out_valid`, output, 1: pooled pixel pulse.
- `out_data`, output, DW: pooled value (signed).
- `out_idx`, output, clog2(N): raster index of the pooled pixel.
- `frame_done`, output, 1: one-cycle pulse after the last pooled pixel.
- `pool_lin_reg`, output, N*DW: pooled map; pixel i is at `[i*DW +: DW]`.

## Operation
- FSM states:
  - IDLE: `in_valid` is ignored; `start` moves to RUN.
  - RUN: samples are accepted; `col`/`row` counters advance on `in_valid`.
  - DONE: one cycle; `frame_done`=1; returns to IDLE.
- Counters:
  - `col` wraps at IMG_W-1 and then increments `row`.
  - After the sample with `row`=IMG_H-1 and `col`=IMG_W-1, the FSM goes to DONE.
- Partial buffer: OW accumulators, one per output column, shared across the K rows of a window band.
  - The first sample of a window (`row%K==0`, `col%K==0`) loads the accumulator directly; no compare against stale data.
  - Max mode: `acc <= (in > acc) ? in : acc`, signed compare.
  - Avg mode: `acc <= acc + in`. Accumulator width is DW+2*log2(K), sign-extended.
  - The last sample of a window (`row%K==K-1`, `col%K==K-1`) produces the result:
    - max: acc updated with that sample;
    - avg: full sum arithmetically shifted right by 2*log2(K), i.e. floor toward −∞.
  - The result is written to `pool_lin_reg[out_idx]` and driven on `out_data`.
- Trailing samples with `col >= OW*K` or `row >= OH*K` are counted but have no other effect.
- `start` in RUN or DONE: counters and accumulators are cleared and RUN restarts. `pool_lin_reg` is retained until overwritten.
- `start` and `in_valid` in the same cycle: `start` wins and the sample is dropped.
- `mode` is sampled when `start` is accepted and is held for the whole frame.

## Timing
- Reset values: all outputs 0, `pool_lin_reg` 0, FSM in IDLE.
- Latency: `out_valid` asserts 1 cycle after the accepted `in_valid` of a window's last sample. `out_data`, `out_idx` and the `pool_lin_reg` slice update on the same edge.
- `out_valid` is high for exactly one cycle per pooled pixel. There is no backpressure; the consumer must accept.
- `frame_done` asserts the cycle after the final input sample. If that sample also closes a window, `frame_done` coincides with the last `out_valid`.
- `busy` = 1 in RUN, 0 in IDLE and DONE.
- Gaps in `in_valid` are allowed at any point; counters hold during gaps.
- Reset asserted mid-frame returns the block to reset values immediately, asynchronously.

## Configuration
- `POOL_AVG_EN` defined: the `mode` port, average datapath, wide accumulators and shifter are built.
- `POOL_AVG_EN` undefined: max pooling only, no `mode` port, DW-wide accumulators.

## Structure
- Package `pool_pkg` holds:
  - the mode encoding constants `POOL_MAX`/`POOL_AVG`;
  - the FSM state encoding;
  - localparams for `OW`, `OH`, `N`, accumulator width and shift amount.
- Sub-module `pool_acc_op`: combinational update for a single accumulator. Inputs are `first`, `mode`, `acc`, `in`; outputs are `next_acc` and `result`. It is instantiated once and muxed by `col/K`.

## Test plan
- DW=8, 4×4, K=2, ramp 0..15 → outputs 5, 7, 13, 15 at `out_idx` 0..3. Each arrives 1 cycle after inputs 5, 7, 13, 15; `frame_done` coincides with the last `out_valid`.
- All-negative window −128, −5, −7, −100 → max −5. Confirms the first sample loads directly and the compare is signed.
- IMG_W=5, IMG_H=4, K=2 → column 4 is ignored; exactly 4 outputs; `frame_done` 1 cycle after sample 19.
- Random `in_valid` gaps on a 4×4 ramp → identical values and `pool_lin_reg` as the gap-free run.
- `start` after 6 samples, then a full ramp → exactly 4 pulses, correct values, no contamination from the aborted frame.
- `POOL_AVG_EN`, `mode`=1, window −1, −2, −3, −4 → −3 (floor of −10/4); window 1, 2, 3, 5 → 2.
